oscillator_bank: RTL and testbench

OSCILLATOR_BANK -- requirements
Module: oscillator_bank

---
 rtl/oscillator_bank.sv | 182 ++++++++++++++++++
 tb/tb_oscillator_bank.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oscillator_bank.sv
`default_nettype none
// ============================================================================
// Module   : oscillator_bank
// Brief    : Independent 50%-duty square-wave oscillators, retuned over a
//            valid/ready port. Define OSC_PHASE_ALIGN_EN to add sync_start.
// Revision : 1.0  initial release
// ============================================================================
module oscillator_bank #(
    parameter int  CHANNELS  = 4,
    parameter int  DIV_WIDTH = 16,
    localparam int CHW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 power,
`ifdef OSC_PHASE_ALIGN_EN
    input  logic                 sync_start,
`endif
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHW-1:0]       cfg_channel,
    input  logic [DIV_WIDTH-1:0] cfg_divisor,
    input  logic                 cfg_enable,
    output logic [CHANNELS-1:0]  osc_out,
    output logic [CHANNELS-1:0]  osc_tick,
    output logic [CHANNELS-1:0]  running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    logic                 r_ready;
    logic                 w_accept;
    logic [DIV_WIDTH-1:0] w_div;

    assign cfg_ready = r_ready & ~power;
    assign w_accept  = cfg_valid & cfg_ready;
    assign w_div     = (cfg_divisor == '0) ? DIV_WIDTH'(1) : cfg_divisor;

    // Ready drops for the single cycle after each accepted transfer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= ~power & ~w_accept;
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            state_t               r_state;
            state_t               w_state;
            state_t               w_state_ref;
            logic [DIV_WIDTH-1:0] r_hp;
            logic [DIV_WIDTH-1:0] w_hp;
            logic [DIV_WIDTH-1:0] r_hp_next;
            logic [DIV_WIDTH-1:0] w_hp_next;
            logic [DIV_WIDTH-1:0] r_cnt;
            logic [DIV_WIDTH-1:0] w_cnt;
            logic                 r_out;
            logic                 w_out;
            logic                 r_tick;
            logic                 w_tick;
            logic                 w_sel;
            logic                 w_wrap;
            logic                 w_wrap_ref;
            logic                 w_out_ref;

            assign w_sel  = w_accept && (cfg_channel == CHW'(i));
            assign w_wrap = (r_cnt == r_hp - DIV_WIDTH'(1));

            always_comb begin
                w_state     = r_state;
                w_hp        = r_hp;
                w_hp_next   = r_hp_next;
                w_cnt       = r_cnt;
                w_out       = r_out;
                w_tick      = 1'b0;
                w_state_ref = r_state;
                w_out_ref   = r_out;
                w_wrap_ref  = w_wrap;

                if (r_state != IDLE) begin
                    if (w_wrap) begin
                        w_cnt = '0;
                        w_out = ~r_out;
                        w_hp  = r_hp_next;
                        if (r_state == STOP) begin
                            w_state = IDLE;
                            w_out   = 1'b0;
                        end
                    end else begin
                        w_cnt = r_cnt + DIV_WIDTH'(1);
                    end
                end

`ifdef OSC_PHASE_ALIGN_EN
                // Alignment is applied first; a same-cycle transfer then sees the aligned channel.
                if (sync_start && (r_state != IDLE)) begin
                    w_cnt       = '0;
                    w_out       = 1'b0;
                    w_hp        = r_hp_next;
                    w_state     = (r_state == STOP) ? IDLE : RUN;
                    w_state_ref = w_state;
                    w_out_ref   = 1'b0;
                    w_wrap_ref  = 1'b0;
                end
`endif

                if (w_sel) begin
                    case (w_state_ref)
                        IDLE: begin
                            if (cfg_enable) begin
                                w_state   = RUN;
                                w_hp      = w_div;
                                w_hp_next = w_div;
                                w_cnt     = '0;
                                w_out     = 1'b0;
                            end
                        end
                        RUN: begin
                            if (cfg_enable) begin
                                w_hp_next = w_div;
                            end else if (w_out_ref && !w_wrap_ref) begin
                                w_state = STOP;
                            end else begin
                                // Low phase, or the high phase ends this very edge.
                                w_state = IDLE;
                                w_cnt   = '0;
                                w_out   = 1'b0;
                            end
                        end
                        STOP: begin
                            if (cfg_enable) begin
                                w_state   = RUN;
                                w_hp_next = w_div;
                            end
                        end
                        default: begin
                            w_state = IDLE;
                        end
                    endcase
                end

                if (power) begin
                    w_state = IDLE;
                    w_cnt   = '0;
                    w_out   = 1'b0;
                end

                w_tick = w_out & ~r_out;
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_state   <= IDLE;
                    r_hp      <= DIV_WIDTH'(1);
                    r_hp_next <= DIV_WIDTH'(1);
                    r_cnt     <= '0;
                    r_out     <= 1'b0;
                    r_tick    <= 1'b0;
                end else begin
                    r_state   <= w_state;
                    r_hp      <= w_hp;
                    r_hp_next <= w_hp_next;
                    r_cnt     <= w_cnt;
                    r_out     <= w_out;
                    r_tick    <= w_tick;
                end
            end

            assign osc_out[i]  = r_out & ~power;
            assign osc_tick[i] = r_tick & ~power;
            assign running[i]  = (r_state != IDLE);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_oscillator_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_oscillator_bank
// Brief    : Directed self-checking bench for oscillator_bank.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_oscillator_bank;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        power = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_channel = 2'd0;
    logic [15:0] cfg_divisor = 16'd0;
    logic        cfg_enable = 1'b0;
    logic [3:0]  osc_out;
    logic [3:0]  osc_tick;
    logic [3:0]  running;

    // Five-channel instance so that an index beyond the last channel is representable.
    logic        cfg_valid5 = 1'b0;
    logic        cfg_ready5;
    logic [2:0]  cfg_channel5 = 3'd0;
    logic [7:0]  cfg_divisor5 = 8'd0;
    logic        cfg_enable5 = 1'b0;
    logic [4:0]  osc_out5;
    logic [4:0]  osc_tick5;
    logic [4:0]  running5;

`ifdef OSC_PHASE_ALIGN_EN
    logic        sync_start = 1'b0;
    logic        sync_start5 = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    oscillator_bank #(.CHANNELS(4), .DIV_WIDTH(16)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .power       (power),
`ifdef OSC_PHASE_ALIGN_EN
        .sync_start  (sync_start),
`endif
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_channel (cfg_channel),
        .cfg_divisor (cfg_divisor),
        .cfg_enable  (cfg_enable),
        .osc_out     (osc_out),
        .osc_tick    (osc_tick),
        .running     (running)
    );

    oscillator_bank #(.CHANNELS(5), .DIV_WIDTH(8)) u_dut5 (
        .clock       (clock),
        .reset       (reset),
        .power       (power),
`ifdef OSC_PHASE_ALIGN_EN
        .sync_start  (sync_start5),
`endif
        .cfg_valid   (cfg_valid5),
        .cfg_ready   (cfg_ready5),
        .cfg_channel (cfg_channel5),
        .cfg_divisor (cfg_divisor5),
        .cfg_enable  (cfg_enable5),
        .osc_out     (osc_out5),
        .osc_tick    (osc_tick5),
        .running     (running5)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        power      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_valid5 = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
    endtask

    // One transfer; returns just after the edge that accepted it.
    task automatic cfg(input int ch, input int dv, input logic en);
        int n;
        n = 0;
        while (!cfg_ready && n < 8) begin
            cyc();
            n++;
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL cfg_ready_wait ch=%0d got=%b want=1", ch, cfg_ready);
        end
        cfg_valid   = 1'b1;
        cfg_channel = ch[1:0];
        cfg_divisor = dv[15:0];
        cfg_enable  = en;
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({osc_out, osc_tick, running} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=000", {osc_out, osc_tick, running});
        end
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b want=0", cfg_ready);
        end
        cyc();
        reset = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge got=%b want=0", cfg_ready);
        end
        cyc();
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_first_edge got=%b want=1", cfg_ready);
        end
        cfg(0, 2, 1'b1);
        repeat (2) cyc();
        checks++;
        if (osc_out !== 4'b0001) begin
            failures++;
            $display("FAIL pre_abort_out got=%b want=0001", osc_out);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({osc_out, osc_tick, running, cfg_ready} !== 13'h0) begin
            failures++;
            $display("FAIL async_abort got=%h want=0", {osc_out, osc_tick, running, cfg_ready});
        end
        cyc();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if ({osc_out, osc_tick} !== 8'h00) begin
                failures++;
                $display("FAIL post_abort k=%0d got=%h want=00", k, {osc_out, osc_tick});
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] e_out;
        logic [3:0] e_tick;
        do_reset();
        cfg(0, 5, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            cyc();
            e_out  = (((k / 5) % 2) == 1) ? 4'b0001 : 4'b0000;
            e_tick = ((k % 10) == 5) ? 4'b0001 : 4'b0000;
            checks++;
            if (osc_out !== e_out) begin
                failures++;
                $display("FAIL basic_out k=%0d got=%b want=%b", k, osc_out, e_out);
            end
            checks++;
            if (osc_tick !== e_tick) begin
                failures++;
                $display("FAIL basic_tick k=%0d got=%b want=%b", k, osc_tick, e_tick);
            end
        end
        checks++;
        if (running !== 4'b0001) begin
            failures++;
            $display("FAIL basic_running got=%b want=0001", running);
        end
    endtask

    task automatic test_retune();
        logic       b;
        logic [3:0] e_tick;
        do_reset();
        cfg(1, 4, 1'b1);
        repeat (5) cyc();
        checks++;
        if (osc_out !== 4'b0010) begin
            failures++;
            $display("FAIL retune_pre got=%b want=0010", osc_out);
        end
        cfg(1, 2, 1'b1);
        for (int k = 7; k <= 16; k++) begin
            cyc();
            b      = (k == 7) ? 1'b1 : ((((k - 8) / 2) % 2) == 1);
            e_tick = (k == 10 || k == 14) ? 4'b0010 : 4'b0000;
            checks++;
            if (osc_out !== {2'b00, b, 1'b0}) begin
                failures++;
                $display("FAIL retune_out k=%0d got=%b want=%b", k, osc_out, {2'b00, b, 1'b0});
            end
            checks++;
            if (osc_tick !== e_tick) begin
                failures++;
                $display("FAIL retune_tick k=%0d got=%b want=%b", k, osc_tick, e_tick);
            end
        end
    endtask

    task automatic test_stop();
        logic [3:0] e;
        do_reset();
        cfg(2, 8, 1'b1);
        repeat (10) cyc();
        checks++;
        if (osc_out !== 4'b0100) begin
            failures++;
            $display("FAIL stop_pre got=%b want=0100", osc_out);
        end
        cfg(2, 0, 1'b0);
        checks++;
        if ({osc_out, running} !== 8'h44) begin
            failures++;
            $display("FAIL stop_enter got=%h want=44", {osc_out, running});
        end
        for (int k = 12; k <= 30; k++) begin
            cyc();
            e = (k <= 15) ? 4'b0100 : 4'b0000;
            checks++;
            if ({osc_out, running, osc_tick} !== {e, e, 4'b0000}) begin
                failures++;
                $display("FAIL stop_tail k=%0d got=%h want=%h", k, {osc_out, running, osc_tick}, {e, e, 4'b0000});
            end
        end
    endtask

    task automatic test_zero_divisor();
        logic [3:0] e;
        do_reset();
        cfg(3, 0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            e = ((k % 2) == 1) ? 4'b1000 : 4'b0000;
            checks++;
            if ({osc_out, osc_tick} !== {e, e}) begin
                failures++;
                $display("FAIL zero_div k=%0d got=%h want=%h", k, {osc_out, osc_tick}, {e, e});
            end
        end
    endtask

    task automatic test_power();
        do_reset();
        cfg(0, 2, 1'b1);
        cfg(1, 3, 1'b1);
        cfg(2, 4, 1'b1);
        cfg(3, 5, 1'b1);
        repeat (5) cyc();
        checks++;
        if ({osc_out, osc_tick, running} !== 12'hFAF) begin
            failures++;
            $display("FAIL power_pre got=%h want=faf", {osc_out, osc_tick, running});
        end
        power = 1'b1;
        #1;
        checks++;
        if ({osc_out, osc_tick, cfg_ready, running} !== 13'h00F) begin
            failures++;
            $display("FAIL power_comb got=%h want=00f", {osc_out, osc_tick, cfg_ready, running});
        end
        cyc();
        checks++;
        if ({osc_out, running, cfg_ready} !== 9'h000) begin
            failures++;
            $display("FAIL power_edge got=%h want=000", {osc_out, running, cfg_ready});
        end
        power = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL power_release_ready got=%b want=0", cfg_ready);
        end
        cyc();
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL power_ready_back got=%b want=1", cfg_ready);
        end
        for (int k = 0; k < 12; k++) begin
            cyc();
            checks++;
            if ({osc_out, running} !== 8'h00) begin
                failures++;
                $display("FAIL power_idle k=%0d got=%h want=00", k, {osc_out, running});
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cfg_valid   = 1'b1;
        cfg_channel = 2'd0;
        cfg_divisor = 16'd3;
        cfg_enable  = 1'b1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready0 got=%b want=1", cfg_ready);
        end
        cyc();
        checks++;
        if ({cfg_ready, running} !== 5'b0_0001) begin
            failures++;
            $display("FAIL b2b_first got=%b want=00001", {cfg_ready, running});
        end
        cfg_channel = 2'd1;
        cfg_divisor = 16'd2;
        cyc();
        checks++;
        if ({cfg_ready, running} !== 5'b1_0001) begin
            failures++;
            $display("FAIL b2b_stalled got=%b want=10001", {cfg_ready, running});
        end
        cyc();
        cfg_valid = 1'b0;
        checks++;
        if ({cfg_ready, running} !== 5'b0_0011) begin
            failures++;
            $display("FAIL b2b_second got=%b want=00011", {cfg_ready, running});
        end

        cfg_valid5   = 1'b1;
        cfg_channel5 = 3'd7;
        cfg_divisor5 = 8'd3;
        cfg_enable5  = 1'b1;
        cyc();
        cfg_valid5 = 1'b0;
        checks++;
        if ({cfg_ready5, running5} !== 6'b0_00000) begin
            failures++;
            $display("FAIL oor_accept got=%b want=000000", {cfg_ready5, running5});
        end
        cyc();
        checks++;
        if ({cfg_ready5, running5, osc_out5} !== 11'b1_00000_00000) begin
            failures++;
            $display("FAIL oor_ignored got=%b want=10000000000", {cfg_ready5, running5, osc_out5});
        end
        cfg_valid5   = 1'b1;
        cfg_channel5 = 3'd4;
        cyc();
        cfg_valid5 = 1'b0;
        checks++;
        if (running5 !== 5'b10000) begin
            failures++;
            $display("FAIL last_channel got=%b want=10000", running5);
        end
    endtask

`ifdef OSC_PHASE_ALIGN_EN
    task automatic test_phase_align();
        logic b0;
        logic b1;
        do_reset();
        cfg(0, 3, 1'b1);
        repeat (2) cyc();
        cfg(1, 5, 1'b1);
        repeat (4) cyc();
        sync_start = 1'b1;
        cyc();
        sync_start = 1'b0;
        checks++;
        if ({osc_out, osc_tick} !== 8'h00) begin
            failures++;
            $display("FAIL align_clear got=%h want=00", {osc_out, osc_tick});
        end
        for (int k = 1; k <= 9; k++) begin
            cyc();
            b0 = (((k / 3) % 2) == 1);
            b1 = (((k / 5) % 2) == 1);
            checks++;
            if (osc_out !== {2'b00, b1, b0}) begin
                failures++;
                $display("FAIL align_out k=%0d got=%b want=%b", k, osc_out, {2'b00, b1, b0});
            end
            checks++;
            if (osc_tick !== {2'b00, (k == 5), (k == 3 || k == 9)}) begin
                failures++;
                $display("FAIL align_tick k=%0d got=%b want=%b", k, osc_tick, {2'b00, (k == 5), (k == 3 || k == 9)});
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_retune();
        test_stop();
        test_zero_divisor();
        test_power();
        test_back_to_back();
`ifdef OSC_PHASE_ALIGN_EN
        test_phase_align();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t limit=500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
